// File: rtl/axis_accumulator_pkg.sv
// Shared types for the AXI-Stream frame accumulator.
package axis_accumulator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/axis_accumulator_channel.sv
// One accumulator channel: sums signed beats over a tlast frame and emits sum/count/ovf.
// AXIS_ACCUMULATOR_SATURATE_EN clamps each addition on overflow instead of wrapping.
module axis_accumulator_channel
  import axis_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = 31,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 16,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [ID_WIDTH-1:0]    s_tid,
  input  logic [USER_WIDTH-1:0]  s_tuser,
  output logic [ACC_WIDTH-1:0]   m_tdata,
  output logic [COUNT_WIDTH-1:0] m_tcount,
  output logic                   m_tovf,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [ID_WIDTH-1:0]    m_tid,
  output logic [USER_WIDTH-1:0]  m_tuser
);

  if (ACC_WIDTH < DATA_WIDTH) begin : g_width_err
    $error("axis_accumulator_channel: ACC_WIDTH must be >= DATA_WIDTH");
  end

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  acc_state_e              state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc, beat_ext, sum_raw, sum;
  logic [COUNT_WIDTH-1:0]  count, count_nxt;
  logic                    ovf, add_ovf, hs;
  logic [USER_WIDTH-1:0]   user_or, user_in;
  logic [ID_WIDTH-1:0]     tid_cap, tid_frame;

  assign s_tready = !m_tvalid || m_tready;
  assign hs       = s_tvalid && s_tready;

  assign beat_ext = ACC_WIDTH'($signed(s_tdata));
  assign sum_raw  = acc + beat_ext;
  assign add_ovf  = (acc[ACC_WIDTH-1] == beat_ext[ACC_WIDTH-1]) &&
                    (sum_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
`ifdef AXIS_ACCUMULATOR_SATURATE_EN
  // Overflow only happens with equal operand signs, so acc's sign picks the rail.
  assign sum = add_ovf ? (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum = sum_raw;
`endif

  assign count_nxt = (&count) ? count : count + 1'b1;
  assign user_in   = (USER_ENABLE != 0) ? s_tuser : '0;
  // A frame's tid comes from its first beat, which for a single-beat frame is this one.
  assign tid_frame = (ID_ENABLE == 0) ? '0 : (state_q == IDLE) ? s_tid : tid_cap;

  always_comb begin
    state_d = state_q;
    if (hs) state_d = s_tlast ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      user_or  <= '0;
      tid_cap  <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tcount <= '0;
      m_tovf   <= 1'b0;
      m_tid    <= '0;
      m_tuser  <= '0;
    end else begin
      state_q <= state_d;
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;
      if (hs) begin
        if (s_tlast) begin
          m_tdata  <= sum;
          m_tcount <= count_nxt;
          m_tovf   <= ovf | add_ovf;
          m_tuser  <= user_or | user_in;
          m_tid    <= tid_frame;
          m_tvalid <= 1'b1;
          acc      <= '0;
          count    <= '0;
          ovf      <= 1'b0;
          user_or  <= '0;
        end else begin
          acc     <= sum;
          count   <= count_nxt;
          ovf     <= ovf | add_ovf;
          user_or <= user_or | user_in;
          if (state_q == IDLE) tid_cap <= tid_frame;
        end
      end
    end
  end

endmodule

// File: rtl/axis_accumulator.sv
// Multi-channel frame accumulator; each channel is an independent axis_accumulator_channel.
// Define AXIS_ACCUMULATOR_SATURATE_EN for saturating instead of wrapping accumulation.
module axis_accumulator
  import axis_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = 31,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 16,
  parameter int CHANNELS    = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [CHANNELS-1:0]             s_axis_tlast,
  input  logic [CHANNELS-1:0]             s_axis_tvalid,
  output logic [CHANNELS-1:0]             s_axis_tready,
  input  logic [CHANNELS*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [CHANNELS*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [CHANNELS*ACC_WIDTH-1:0]   m_axis_tdata,
  output logic [CHANNELS*COUNT_WIDTH-1:0] m_axis_tcount,
  output logic [CHANNELS-1:0]             m_axis_tovf,
  output logic [CHANNELS-1:0]             m_axis_tlast,
  output logic [CHANNELS-1:0]             m_axis_tvalid,
  input  logic [CHANNELS-1:0]             m_axis_tready,
  output logic [CHANNELS*ID_WIDTH-1:0]    m_axis_tid,
  output logic [CHANNELS*USER_WIDTH-1:0]  m_axis_tuser
);

  assign m_axis_tlast = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    axis_accumulator_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH),
      .ID_ENABLE  (ID_ENABLE),
      .ID_WIDTH   (ID_WIDTH),
      .USER_ENABLE(USER_ENABLE),
      .USER_WIDTH (USER_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .s_tdata (s_axis_tdata [c*DATA_WIDTH  +: DATA_WIDTH]),
      .s_tlast (s_axis_tlast [c]),
      .s_tvalid(s_axis_tvalid[c]),
      .s_tready(s_axis_tready[c]),
      .s_tid   (s_axis_tid   [c*ID_WIDTH    +: ID_WIDTH]),
      .s_tuser (s_axis_tuser [c*USER_WIDTH  +: USER_WIDTH]),
      .m_tdata (m_axis_tdata [c*ACC_WIDTH   +: ACC_WIDTH]),
      .m_tcount(m_axis_tcount[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .m_tovf  (m_axis_tovf  [c]),
      .m_tvalid(m_axis_tvalid[c]),
      .m_tready(m_axis_tready[c]),
      .m_tid   (m_axis_tid   [c*ID_WIDTH    +: ID_WIDTH]),
      .m_tuser (m_axis_tuser [c*USER_WIDTH  +: USER_WIDTH])
    );
  end

endmodule

// File: tb/tb_axis_accumulator.sv
// Randomized scoreboard bench for axis_accumulator (small widths to hit overflow and count saturation).
module tb_axis_accumulator;
  localparam int DW = 8, AW = 10, CW = 3, CH = 2, IW = 4, UW = 2;
  localparam int NFRAMES = 40;

  typedef struct {
    logic signed [DW-1:0] d;
    bit                   last;
    logic [IW-1:0]        id;
    logic [UW-1:0]        u;
  } beat_t;
  typedef struct {
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    bit            ovf;
    logic [IW-1:0] id;
    logic [UW-1:0] u;
  } exp_t;

  logic                 clk = 0, rst = 1;
  logic [CH*DW-1:0]     s_axis_tdata = '0;
  logic [CH-1:0]        s_axis_tlast = '0, s_axis_tvalid = '0, s_axis_tready;
  logic [CH*IW-1:0]     s_axis_tid = '0;
  logic [CH*UW-1:0]     s_axis_tuser = '0;
  logic [CH*AW-1:0]     m_axis_tdata;
  logic [CH*CW-1:0]     m_axis_tcount;
  logic [CH-1:0]        m_axis_tovf, m_axis_tlast, m_axis_tvalid, m_axis_tready = '1;
  logic [CH*IW-1:0]     m_axis_tid;
  logic [CH*UW-1:0]     m_axis_tuser;

  int vectors = 0, miscompares = 0;
  bit done = 0;
  beat_t bq[CH][$];
  exp_t  eq[CH][$];

  axis_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW), .CHANNELS(CH),
    .ID_ENABLE(1), .ID_WIDTH(IW), .USER_ENABLE(1), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tid(s_axis_tid), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tcount(m_axis_tcount),
    .m_axis_tovf(m_axis_tovf), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Reference: exact integer sum per beat, then range check -> wrap or clamp.
  function automatic exp_t model(input beat_t fr[$]);
    exp_t   e;
    longint acc = 0, s;
    longint hi = (longint'(1) <<< (AW-1)) - 1;
    longint lo = -(longint'(1) <<< (AW-1));
    longint span = longint'(1) <<< AW;
    e.ovf = 0; e.u = '0; e.id = fr[0].id;
    foreach (fr[i]) begin
      s = acc + longint'(fr[i].d);
      if (s > hi || s < lo) begin
        e.ovf = 1;
`ifdef AXIS_ACCUMULATOR_SATURATE_EN
        s = (s > hi) ? hi : lo;
`else
        s = (s > hi) ? s - span : s + span;
`endif
      end
      acc = s;
      e.u |= fr[i].u;
    end
    e.sum = AW'(acc);
    e.cnt = (fr.size() > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(fr.size());
    return e;
  endfunction

  task automatic add_frame(input int c, input int vals[$], input logic [UW-1:0] users[$]);
    beat_t fr[$];
    beat_t b;
    logic [IW-1:0] fid = IW'($urandom);
    foreach (vals[i]) begin
      b.d = DW'(vals[i]); b.last = (i == vals.size() - 1);
      b.id = (i == 0) ? fid : IW'($urandom); b.u = users[i];
      fr.push_back(b); bq[c].push_back(b);
    end
    eq[c].push_back(model(fr));
  endtask

  // Monitor: pops expected results on each output handshake; also checks hold and ready rules.
  initial begin
    logic [AW-1:0] hd[CH];
    bit            held[CH];
    exp_t          e;
    for (int c = 0; c < CH; c++) begin held[c] = 0; hd[c] = '0; end
    wait (rst == 0);
    while (!done) begin
      @(negedge clk);
      if (rst) continue;
      for (int c = 0; c < CH; c++) begin
        chk("s_tready", c, 64'(s_axis_tready[c]), 64'(!m_axis_tvalid[c] || m_axis_tready[c]));
        if (m_axis_tvalid[c]) begin
          if (held[c]) chk("hold_tdata", c, 64'(m_axis_tdata[c*AW +: AW]), 64'(hd[c]));
          if (m_axis_tready[c]) begin
            if (eq[c].size() == 0) begin
              chk("unexpected_beat", c, 64'd1, 64'd0);
            end else begin
              e = eq[c].pop_front();
              chk("tdata",  c, 64'(m_axis_tdata[c*AW +: AW]),  64'(e.sum));
              chk("tcount", c, 64'(m_axis_tcount[c*CW +: CW]), 64'(e.cnt));
              chk("tovf",   c, 64'(m_axis_tovf[c]),            64'(e.ovf));
              chk("tid",    c, 64'(m_axis_tid[c*IW +: IW]),    64'(e.id));
              chk("tuser",  c, 64'(m_axis_tuser[c*UW +: UW]),  64'(e.u));
              chk("tlast",  c, 64'(m_axis_tlast[c]),           64'd1);
            end
          end
        end
        held[c] = m_axis_tvalid[c] && !m_axis_tready[c];
        hd[c]   = m_axis_tdata[c*AW +: AW];
      end
    end
  end

  initial begin
    bit hs[CH];
    int vals[$];
    logic [UW-1:0] us[$];
    int cyc;
    bit busy;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 0, 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata",  0, 64'(m_axis_tdata),  64'd0);
    chk("rst_tcount", 0, 64'(m_axis_tcount), 64'd0);
    chk("rst_tid",    0, 64'({m_axis_tid, m_axis_tuser, m_axis_tovf}), 64'd0);
    @(posedge clk); #1 rst = 0;
    // Partial frame 5,7 on ch0 killed by reset: must never appear
    s_axis_tvalid[0] = 1; s_axis_tdata[0 +: DW] = 8'd5;
    @(posedge clk); #1 s_axis_tdata[0 +: DW] = 8'd7;
    @(posedge clk); #1 s_axis_tvalid[0] = 0;
    #2 rst = 1;
    @(negedge clk);
    chk("midrst_tvalid", 0, 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1 rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_out", 0, 64'(m_axis_tvalid), 64'd0);
    end

    // Directed frames first, then random frames
    vals = '{1, 2};        us = '{2'd0, 2'd0};        add_frame(0, vals, us);
    vals = '{3, -10, 4};   us = '{2'd0, 2'd1, 2'd0};  add_frame(1, vals, us);
    vals = '{100, 100};    us = '{2'd0, 2'd0};        add_frame(0, vals, us);
    for (int v = 8; v <= 10; v++) begin
      vals = '{v}; us = '{2'd0}; add_frame(1, vals, us);
    end
    for (int c = 0; c < CH; c++)
      for (int f = 0; f < NFRAMES; f++) begin
        int n = $urandom_range(1, 10);
        vals = {}; us = {};
        for (int i = 0; i < n; i++) begin
          vals.push_back(int'($signed(DW'($urandom))));
          us.push_back(($urandom_range(0, 7) == 0) ? UW'($urandom) : '0);
        end
        add_frame(c, vals, us);
      end

    cyc = 0;
    busy = 1;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) hs[c] = s_axis_tvalid[c] && s_axis_tready[c];
      @(posedge clk); #1;
      busy = 0;
      for (int c = 0; c < CH; c++) begin
        if (hs[c]) void'(bq[c].pop_front());
        if (!s_axis_tvalid[c] || hs[c]) begin
          if (bq[c].size() > 0 && $urandom_range(0, 3) != 0) begin
            s_axis_tvalid[c] = 1;
            s_axis_tdata[c*DW +: DW] = bq[c][0].d;
            s_axis_tlast[c] = bq[c][0].last;
            s_axis_tid[c*IW +: IW] = bq[c][0].id;
            s_axis_tuser[c*UW +: UW] = bq[c][0].u;
          end else s_axis_tvalid[c] = 0;
        end
        m_axis_tready[c] = ($urandom_range(0, 3) != 0);
        if (bq[c].size() > 0 || s_axis_tvalid[c]) busy = 1;
      end
      cyc++;
    end
    if (busy) chk("stim_timeout", 0, 64'd1, 64'd0);
    m_axis_tready = '1;
    repeat (20) @(posedge clk);
    done = 1;
    @(negedge clk);
    for (int c = 0; c < CH; c++) chk("frames_left", c, 64'(eq[c].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
